buff_fifo: RTL

BUFF_FIFO -- requirements
Module: buff_fifo

---
 rtl/buff_fifo.sv | 119 +++++++++++
 1 files changed

// File: rtl/buff_fifo.sv
// First-word fall-through FIFO with registered head data and status.
// The head word is computed ahead of the clock edge so Y and all flags come straight from flops.
module buff_fifo #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int d_Y   = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [N-1:0]  IN0,
  input  logic          WR_VALID,
  output logic          WR_READY,
  output logic [N-1:0]  Y,
  output logic          RD_VALID,
  input  logic          RD_READY,
  output logic [AW:0]   COUNT,
  output logic          FULL,
  output logic          EMPTY
);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  // Reject geometries where the pointer does not wrap exactly at DEPTH.
  if ((DEPTH < 2) || (DEPTH != (1 << AW)) || (d_Y < 0)) begin : g_param_err
    $error("buff_fifo: DEPTH must be 2**AW, at least 2, and d_Y non-negative");
  end

  logic [N-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_r;
  logic          empty_r;
  logic [N-1:0]  y_r;

  logic          push_s;
  logic          pop_s;
  logic [AW-1:0] wr_ptr_nxt_s;
  logic [AW-1:0] rd_ptr_nxt_s;
  logic [AW:0]   count_nxt_s;
  logic [N-1:0]  y_nxt_s;

  // Handshake qualification: only registered flags gate the transfers.
  always_comb begin
    push_s = WR_VALID && !full_r;
    pop_s  = RD_READY && !empty_r;
  end

  // Next pointers and occupancy.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Next head word: the word being written lands at the head when it is the only one left.
  always_comb begin
    y_nxt_s = {N{1'b0}};
    if (count_nxt_s == {(AW+1){1'b0}}) begin
      y_nxt_s = {N{1'b0}};
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      y_nxt_s = IN0;
    end else begin
      y_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage array, intentionally without reset.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= IN0;
    end
  end

  // Pointers, occupancy, flags and head register; reset wins over any transfer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      y_r      <= {N{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == CNT_DEPTH);
      empty_r  <= (count_nxt_s == {(AW+1){1'b0}});
      y_r      <= y_nxt_s;
    end
  end

  assign Y        = y_r;
  assign COUNT    = count_r;
  assign FULL     = full_r;
  assign EMPTY    = empty_r;
  assign WR_READY = !full_r;
  assign RD_VALID = !empty_r;

endmodule
